// File: rtl/simmem_release_scheduler.sv
// simmem_release_scheduler
//
// Picks one write-response bank entry at a time from those whose delay has
// expired. The pick is always the oldest allocation, so responses that share
// an AXI ID leave in the order they were stored. The chosen address is offered
// to the response bank read port over a valid/ready request. In the handshake
// cycle, a one-hot of the released address goes back to the delay bank so that
// it can clear the entry.
//
// Ports
//   clk_i                      clock
//   rst_ni                     asynchronous active-low reset
//   alloc_valid_i              an entry is allocated this cycle
//   alloc_addr_i               address of the allocated entry
//   release_en_i               multihot of entries whose delay expired
//   rsp_valid_o                release request valid
//   rsp_addr_o                 entry address to read from the response bank
//   rsp_ready_i                response bank accepts the request
//   address_released_onehot_o  one-hot of the entry released this cycle, else 0

module simmem_release_scheduler #(
  parameter int unsigned NumEntries = 16,
  parameter int unsigned AddrWidth  = $clog2(NumEntries)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  alloc_valid_i,
  input  logic [AddrWidth-1:0]  alloc_addr_i,
  input  logic [NumEntries-1:0] release_en_i,
  output logic                  rsp_valid_o,
  output logic [AddrWidth-1:0]  rsp_addr_o,
  input  logic                  rsp_ready_i,
  output logic [NumEntries-1:0] address_released_onehot_o
);

  typedef enum logic {
    IDLE,
    OFFER
  } state_e;

  state_e                state_q, state_d;
  logic [AddrWidth-1:0]  addr_q, addr_d;

  // older_q[i][j] = 1 : entry i was allocated before entry j (diagonal unused)
  logic [NumEntries-1:0] older_q     [NumEntries];
  logic [NumEntries-1:0] older_d     [NumEntries];
  // older_than[i][j] = 1 : entry j is older than entry i (column i of older_q)
  logic [NumEntries-1:0] older_than  [NumEntries];

  logic [NumEntries-1:0] excl;
  logic [NumEntries-1:0] cand;
  logic [NumEntries-1:0] unbeaten;
  logic                  win_found;
  logic [AddrWidth-1:0]  win_addr;
  logic                  handshake;

  assign rsp_valid_o = (state_q == OFFER);
  assign rsp_addr_o  = addr_q;
  assign handshake   = rsp_valid_o & rsp_ready_i;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int unsigned i = 0; i < NumEntries; i++) begin
      for (int unsigned j = 0; j < NumEntries; j++) begin
        older_than[i][j] = (i != j) ? older_q[j][i] : 1'b0;
      end
    end
  end

  // The entry being offered stays set in release_en_i until the delay bank
  // clears it after the handshake. It is masked here so that, in the handshake
  // cycle, the next winner can be chosen without offering the same entry twice.
  always_comb begin
    excl = '0;
    if (rsp_valid_o) begin
      excl[rsp_addr_o] = 1'b1;
    end
    cand = release_en_i & ~excl;
  end

  // A candidate wins when no other candidate is older than it. Entries that
  // were never allocated after reset have no ordering between them, so several
  // may be unbeaten. The lowest index among them is taken.
  always_comb begin
    for (int unsigned i = 0; i < NumEntries; i++) begin
      unbeaten[i] = cand[i] & ~|(cand & older_than[i]);
    end
  end

  always_comb begin
    win_found = 1'b0;
    win_addr  = '0;
    for (int unsigned i = 0; i < NumEntries; i++) begin
      if (unbeaten[i] && !win_found) begin
        win_found = 1'b1;
        win_addr  = AddrWidth'(i);
      end
    end
  end

  always_comb begin
    address_released_onehot_o = '0;
    if (handshake) begin
      address_released_onehot_o[rsp_addr_o] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Age matrix: an allocated entry becomes younger than every other entry
  // ---------------------------------------------------------------------------
  always_comb begin
    older_d = older_q;
    if (alloc_valid_i) begin
      for (int unsigned k = 0; k < NumEntries; k++) begin
        older_d[alloc_addr_i][k] = 1'b0;
        older_d[k][alloc_addr_i] = 1'b1;
      end
      older_d[alloc_addr_i][alloc_addr_i] = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Request FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = OFFER;
          addr_d  = win_addr;
        end
      end
      OFFER: begin
        // No preemption: the offered address is held until it is accepted.
        if (handshake) begin
          if (win_found) begin
            addr_d = win_addr;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      for (int unsigned i = 0; i < NumEntries; i++) begin
        older_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      older_q <= older_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Usage checks
  // ---------------------------------------------------------------------------
  // Allocating the entry that is on offer would overwrite a pending response.
  // In the handshake cycle the entry is already released, so this is allowed.
  alloc_to_offered_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(alloc_valid_i && rsp_valid_o && !rsp_ready_i && (alloc_addr_i == rsp_addr_o)));

  // The delay bank must keep the offered entry enabled until it is accepted.
  release_held_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    rsp_valid_o |-> release_en_i[rsp_addr_o]);

endmodule

// File: tb/tb_simmem_release_scheduler.sv
// Testbench for simmem_release_scheduler.
//
// Directed vector tables cover reset, ordered release, stall/hold, the no-
// preemption rule, allocation during a handshake and asynchronous reset. A
// seeded random phase follows, checked against a timestamp-based age model.
// The bench also models the delay bank: release_en bits stay set until the
// expected release one-hot clears them.

module tb_simmem_release_scheduler;

  localparam int unsigned N  = 16;
  localparam int unsigned AW = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          alloc_valid_i;
  logic [AW-1:0] alloc_addr_i;
  logic [N-1:0]  release_en_i;
  logic          rsp_valid_o;
  logic [AW-1:0] rsp_addr_o;
  logic          rsp_ready_i;
  logic [N-1:0]  address_released_onehot_o;

  always #5 clk_i = ~clk_i;

  simmem_release_scheduler #(
    .NumEntries (N),
    .AddrWidth  (AW)
  ) dut (
    .clk_i                     (clk_i),
    .rst_ni                    (rst_ni),
    .alloc_valid_i             (alloc_valid_i),
    .alloc_addr_i              (alloc_addr_i),
    .release_en_i              (release_en_i),
    .rsp_valid_o               (rsp_valid_o),
    .rsp_addr_o                (rsp_addr_o),
    .rsp_ready_i               (rsp_ready_i),
    .address_released_onehot_o (address_released_onehot_o)
  );

  typedef struct {
    int            tag;
    logic          exp_valid;
    logic [AW-1:0] exp_addr;
    logic          chk_addr;
    logic [N-1:0]  exp_oh;
  } exp_t;

  typedef struct {
    logic          rst_n;
    logic          alloc_v;
    logic [AW-1:0] alloc_a;
    logic [N-1:0]  rel_set;
    logic          ready;
    exp_t          e;
  } vec_t;

  exp_t         sb[$];
  vec_t         vecs[$];
  int           n_vec = 0;
  int           n_mis = 0;
  logic [N-1:0] rel   = '0;

  function automatic vec_t mk(input int tag, input logic rst_n, input logic av,
                              input int aa, input logic [N-1:0] rs, input logic rdy,
                              input logic ev, input int ea, input logic [N-1:0] eo);
    vec_t v;
    v.rst_n       = rst_n;
    v.alloc_v     = av;
    v.alloc_a     = AW'(aa);
    v.rel_set     = rs;
    v.ready       = rdy;
    v.e.tag       = tag;
    v.e.exp_valid = ev;
    v.e.exp_addr  = AW'(ea);
    v.e.chk_addr  = ev | ~rst_n;
    v.e.exp_oh    = eo;
    return v;
  endfunction

  task automatic check_out();
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_mis++;
      $display("FAIL scoreboard: no expected entry for vector %0d", n_vec);
    end else begin
      e = sb.pop_front();
      if (rsp_valid_o !== e.exp_valid || address_released_onehot_o !== e.exp_oh ||
          (e.chk_addr && rsp_addr_o !== e.exp_addr)) begin
        n_mis++;
        $display("FAIL vec%0d test%0d: valid=%0b addr=%0d onehot=%h, expected valid=%0b addr=%0d onehot=%h",
                 n_vec, e.tag, rsp_valid_o, rsp_addr_o, address_released_onehot_o,
                 e.exp_valid, e.exp_addr, e.exp_oh);
      end
    end
  endtask

  // Drive one cycle of stimulus at the falling edge, sample 1ns later, and
  // let the delay-bank model clear the entry the cycle is expected to release.
  task automatic apply(input logic rst_n, input logic av, input logic [AW-1:0] aa,
                       input logic [N-1:0] rs, input logic rdy, input exp_t e);
    @(negedge clk_i);
    if (!rst_n) rel = '0;
    rel           = rel | rs;
    rst_ni        = rst_n;
    alloc_valid_i = av;
    alloc_addr_i  = aa;
    release_en_i  = rel;
    rsp_ready_i   = rdy;
    sb.push_back(e);
    #1;
    check_out();
    rel = rel & ~e.exp_oh;
  endtask

  // Timestamp reference model for the random phase
  int unsigned   stamp[N];
  int unsigned   cnt;
  logic          m_valid;
  logic [AW-1:0] m_addr;

  initial begin
    exp_t          e;
    logic          rdy, av;
    logic [AW-1:0] aa, w;
    logic [N-1:0]  rs, c, bit_cur;
    logic          found;
    int unsigned   best;

    rst_ni        = 1'b0;
    alloc_valid_i = 1'b0;
    alloc_addr_i  = '0;
    release_en_i  = '0;
    rsp_ready_i   = 1'b0;

    // 1: reset and idle
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 0, 0, 16'h0, 0, 0, 0, 16'h0));
    for (int i = 0; i < 7; i++) vecs.push_back(mk(1, 1, 0, 0, 16'h0, 0, 0, 0, 16'h0));
    // 2: alloc 5,2,9; all expire together; released in allocation order
    vecs.push_back(mk(2, 1, 1, 5, 16'h0,    1, 0, 0, 16'h0));
    vecs.push_back(mk(2, 1, 1, 2, 16'h0,    1, 0, 0, 16'h0));
    vecs.push_back(mk(2, 1, 1, 9, 16'h0,    1, 0, 0, 16'h0));
    vecs.push_back(mk(2, 1, 0, 0, 16'h0224, 1, 0, 0, 16'h0));
    vecs.push_back(mk(2, 1, 0, 0, 16'h0,    1, 1, 5, 16'h0020));
    vecs.push_back(mk(2, 1, 0, 0, 16'h0,    1, 1, 2, 16'h0004));
    vecs.push_back(mk(2, 1, 0, 0, 16'h0,    1, 1, 9, 16'h0200));
    vecs.push_back(mk(2, 1, 0, 0, 16'h0,    1, 0, 0, 16'h0));
    // 3: single entry held while not ready, released once
    vecs.push_back(mk(3, 1, 1, 3, 16'h0,    0, 0, 0, 16'h0));
    vecs.push_back(mk(3, 1, 0, 0, 16'h0008, 0, 0, 0, 16'h0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(3, 1, 0, 0, 16'h0, 0, 1, 3, 16'h0));
    vecs.push_back(mk(3, 1, 0, 0, 16'h0,    1, 1, 3, 16'h0008));
    vecs.push_back(mk(3, 1, 0, 0, 16'h0,    1, 0, 0, 16'h0));
    // 4: no preemption by an older entry
    vecs.push_back(mk(4, 1, 1, 1, 16'h0,    0, 0, 0, 16'h0));
    vecs.push_back(mk(4, 1, 1, 7, 16'h0,    0, 0, 0, 16'h0));
    vecs.push_back(mk(4, 1, 0, 0, 16'h0080, 0, 0, 0, 16'h0));
    vecs.push_back(mk(4, 1, 0, 0, 16'h0,    0, 1, 7, 16'h0));
    vecs.push_back(mk(4, 1, 0, 0, 16'h0002, 0, 1, 7, 16'h0));
    vecs.push_back(mk(4, 1, 0, 0, 16'h0,    0, 1, 7, 16'h0));
    vecs.push_back(mk(4, 1, 0, 0, 16'h0,    1, 1, 7, 16'h0080));
    vecs.push_back(mk(4, 1, 0, 0, 16'h0,    1, 1, 1, 16'h0002));
    vecs.push_back(mk(4, 1, 0, 0, 16'h0,    1, 0, 0, 16'h0));
    // 5: re-alloc of 4 during its handshake makes 4 younger than 6
    vecs.push_back(mk(5, 1, 1, 4, 16'h0,    1, 0, 0, 16'h0));
    vecs.push_back(mk(5, 1, 1, 6, 16'h0,    1, 0, 0, 16'h0));
    vecs.push_back(mk(5, 1, 0, 0, 16'h0010, 1, 0, 0, 16'h0));
    vecs.push_back(mk(5, 1, 1, 4, 16'h0,    1, 1, 4, 16'h0010));
    vecs.push_back(mk(5, 1, 0, 0, 16'h0050, 1, 0, 0, 16'h0));
    vecs.push_back(mk(5, 1, 0, 0, 16'h0,    1, 1, 6, 16'h0040));
    vecs.push_back(mk(5, 1, 0, 0, 16'h0,    1, 1, 4, 16'h0010));
    vecs.push_back(mk(5, 1, 0, 0, 16'h0,    1, 0, 0, 16'h0));
    // 6: async reset mid-offer; afterwards 2 and 3 tie (3 was older before reset)
    vecs.push_back(mk(6, 1, 1, 3, 16'h0,    0, 0, 0, 16'h0));
    vecs.push_back(mk(6, 1, 1, 2, 16'h0,    0, 0, 0, 16'h0));
    vecs.push_back(mk(6, 1, 0, 0, 16'h0020, 0, 0, 0, 16'h0));
    vecs.push_back(mk(6, 1, 0, 0, 16'h0,    0, 1, 5, 16'h0));
    vecs.push_back(mk(6, 0, 0, 0, 16'h0,    0, 0, 0, 16'h0));
    vecs.push_back(mk(6, 0, 0, 0, 16'h0,    0, 0, 0, 16'h0));
    vecs.push_back(mk(6, 1, 0, 0, 16'h000C, 1, 0, 0, 16'h0));
    vecs.push_back(mk(6, 1, 0, 0, 16'h0,    1, 1, 2, 16'h0004));
    vecs.push_back(mk(6, 1, 0, 0, 16'h0,    1, 1, 3, 16'h0008));
    vecs.push_back(mk(6, 1, 0, 0, 16'h0,    1, 0, 0, 16'h0));

    foreach (vecs[k]) begin
      apply(vecs[k].rst_n, vecs[k].alloc_v, vecs[k].alloc_a, vecs[k].rel_set,
            vecs[k].ready, vecs[k].e);
    end

    // 7: random traffic against the timestamp model. The age state is clear
    // after the reset in test 6, so all stamps start equal.
    for (int i = 0; i < N; i++) stamp[i] = 0;
    cnt     = 0;
    m_valid = 1'b0;
    m_addr  = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rdy = ($urandom_range(0, 3) != 0);
      av  = ($urandom_range(0, 2) == 0);
      aa  = AW'($urandom_range(0, N - 1));
      if (m_valid && !rdy && aa == m_addr) av = 1'b0;
      rs = '0;
      if ($urandom_range(0, 2) == 0) rs[$urandom_range(0, N - 1)] = 1'b1;
      if ($urandom_range(0, 5) == 0) rs[$urandom_range(0, N - 1)] = 1'b1;

      bit_cur = '0;
      bit_cur[m_addr] = 1'b1;
      e.tag       = 7;
      e.exp_valid = m_valid;
      e.exp_addr  = m_addr;
      e.chk_addr  = m_valid;
      e.exp_oh    = (m_valid && rdy) ? bit_cur : '0;
      apply(1'b1, av, aa, rs, rdy, e);

      c     = release_en_i & ~(m_valid ? bit_cur : '0);
      found = 1'b0;
      w     = '0;
      best  = 0;
      for (int i = 0; i < N; i++) begin
        if (c[i] && (!found || stamp[i] < best)) begin
          found = 1'b1;
          best  = stamp[i];
          w     = AW'(i);
        end
      end
      if (!m_valid) begin
        if (found) begin
          m_valid = 1'b1;
          m_addr  = w;
        end
      end else if (rdy) begin
        if (found) m_addr = w;
        else       m_valid = 1'b0;
      end
      if (av) begin
        cnt++;
        stamp[aa] = cnt;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
